seg7_scan_decoder: RTL and testbench

//  Receive-side counterpart of the 4-digit 7-seg scan driver. Snoops the multiplexed
//  a_to_g/an/dp lines and rebuilds the 16-bit nibble value being displayed.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_pattern_decode.sv | 35 +++
 rtl/seg7_scan_decoder.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the scan driver (encode) and scan decoder (decode).
// Patterns are active-low, bit6=g .. bit0=a. Keeping both tables on these constants
// means encode and decode cannot drift apart.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS       = 4;
  localparam int unsigned DP_DIGIT_DEFAULT = 2;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nib_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;  // nibble A
  localparam seg_t SEG_BLANK = 7'b1111111;  // nibble B
  localparam seg_t SEG_C     = 7'b1110111;  // nibble C

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to nibble decoder.
// Ports:
//   seg  in  7  active-low segment pattern, bit6=g .. bit0=a
//   nib  out 4  decoded nibble; F for any pattern not in the table
//   bad  out 1  pattern not in the table
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       bad
);

  always_comb begin
    nib = 4'hF;
    bad = 1'b0;
    case (seg)
      SEG_0:     nib = 4'h0;
      SEG_1:     nib = 4'h1;
      SEG_2:     nib = 4'h2;
      SEG_3:     nib = 4'h3;
      SEG_4:     nib = 4'h4;
      SEG_5:     nib = 4'h5;
      SEG_6:     nib = 4'h6;
      SEG_7:     nib = 4'h7;
      SEG_8:     nib = 4'h8;
      SEG_9:     nib = 4'h9;
      SEG_DASH:  nib = 4'hA;
      SEG_BLANK: nib = 4'hB;
      SEG_C:     nib = 4'hC;
      default:   bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed 4-digit 7-segment bus and rebuilds the 16-bit value displayed.
// Ports:
//   clk        in   1   system clock
//   clr        in   1   asynchronous active-high reset
//   a_to_g     in   7   segment lines, active-low, bit6=g .. bit0=a
//   an         in   4   digit anodes, active-low
//   dp         in   1   dot line, active-low
//   x          out  16  reconstructed value, x[4i+3:4i] = digit i
//   valid      out  1   x holds a complete frame and no timeout since
//   frame_done out  1   one-cycle pulse when x updates
//   dec_err    out  1   sticky: captured segment pattern not decodable
//   dp_err     out  1   sticky: dot level wrong for captured digit
//   an_err     out  1   sticky: several anodes low in a settled sample
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DP_DIGIT      = DP_DIGIT_DEFAULT,
  parameter int unsigned TIMEOUT_W     = 20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [6:0]  a_to_g,
  input  logic [3:0]  an,
  input  logic        dp,
  output logic [15:0] x,
  output logic        valid,
  output logic        frame_done,
  output logic        dec_err,
  output logic        dp_err,
  output logic        an_err
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  // Synchronizers reset to an idle (blanked) bus so the reset value never settles as a
  // multi-anode sample.
  localparam logic [11:0] SmpIdle = {4'hF, 1'b1, SEG_BLANK};

  logic [11:0]           sync1_q, smp_q, prev_q;
  logic [CntW-1:0]       stab_cnt_q, stab_cnt_d;
  logic [15:0]           shadow_q, shadow_d, x_q, x_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [TIMEOUT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic                  valid_q, valid_d, frame_done_q, frame_done_d;
  logic                  dec_err_q, dec_err_d, dp_err_q, dp_err_d, an_err_q, an_err_d;

  logic [3:0]      an_low;
  logic            an_one, an_multi, settled, complete, timeout, bad;
  logic [3:0]      nib;
  logic [IdxW-1:0] idx;

  seg7_pattern_decode u_decode (
    .seg (smp_q[6:0]),
    .nib (nib),
    .bad (bad)
  );

  assign an_low   = ~smp_q[11:8];
  assign an_one   = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
  assign an_multi = (an_low != 4'd0) && !an_one;

  always_comb begin
    idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (an_low[i]) idx = IdxW'(i);
    end
  end

  always_comb begin
    if (smp_q != prev_q) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q == CntW'(SETTLE_CYCLES)) begin
      stab_cnt_d = stab_cnt_q;
    end else begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end
  end

  // Counter passes through SETTLE_CYCLES-1 once per dwell, giving one capture per dwell.
  assign settled  = (stab_cnt_d == CntW'(SETTLE_CYCLES - 1));
  // seen only reaches all-ones via a capture, and is cleared on the following edge.
  assign complete = &seen_q;
  assign timeout  = (tmo_cnt_q == '1);

  always_comb begin
    shadow_d     = shadow_q;
    seen_d       = seen_q;
    x_d          = x_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    tmo_cnt_d    = tmo_cnt_q + 1'b1;
    dec_err_d    = dec_err_q;
    dp_err_d     = dp_err_q;
    an_err_d     = an_err_q;

    if (complete) begin
      x_d          = shadow_q;
      valid_d      = 1'b1;
      frame_done_d = 1'b1;
      seen_d       = '0;
      tmo_cnt_d    = '0;
    end else if (timeout) begin
      valid_d = 1'b0;
      seen_d  = '0;
    end

    if (settled) begin
      if (an_one) begin
        shadow_d[{idx, 2'b00} +: 4] = nib;
        seen_d[idx] = 1'b1;
        if (bad) dec_err_d = 1'b1;
        if ((smp_q[7] == 1'b0) != (idx == IdxW'(DP_DIGIT))) dp_err_d = 1'b1;
      end else if (an_multi) begin
        an_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q      <= SmpIdle;
      smp_q        <= SmpIdle;
      prev_q       <= SmpIdle;
      stab_cnt_q   <= '0;
      shadow_q     <= '0;
      seen_q       <= '0;
      x_q          <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      tmo_cnt_q    <= '0;
      dec_err_q    <= 1'b0;
      dp_err_q     <= 1'b0;
      an_err_q     <= 1'b0;
    end else begin
      sync1_q      <= {an, dp, a_to_g};
      smp_q        <= sync1_q;
      prev_q       <= smp_q;
      stab_cnt_q   <= stab_cnt_d;
      shadow_q     <= shadow_d;
      seen_q       <= seen_d;
      x_q          <= x_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      tmo_cnt_q    <= tmo_cnt_d;
      dec_err_q    <= dec_err_d;
      dp_err_q     <= dp_err_d;
      an_err_q     <= an_err_d;
    end
  end

  assign x          = x_q;
  assign valid      = valid_q;
  assign frame_done = frame_done_q;
  assign dec_err    = dec_err_q;
  assign dp_err     = dp_err_q;
  assign an_err     = an_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus pushes the expected frame before the
// final digit of each scan; a monitor pops and compares on every frame_done pulse.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [6:0]  a_to_g = 7'b1111111;
  logic [3:0]  an = 4'b1111;
  logic        dp = 1'b1;
  logic [15:0] x;
  logic        valid, frame_done, dec_err, dp_err, an_err;

  typedef struct {
    logic [15:0] x;
    logic        dec;
    logic        dpe;
    logic        ane;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   drive_cyc = 0;

  seg7_scan_decoder #(
    .SETTLE_CYCLES (4),
    .DP_DIGIT      (2),
    .TIMEOUT_W     (8)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .a_to_g     (a_to_g),
    .an         (an),
    .dp         (dp),
    .x          (x),
    .valid      (valid),
    .frame_done (frame_done),
    .dec_err    (dec_err),
    .dp_err     (dp_err),
    .an_err     (an_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Independent hand-written encode table; F maps to a pattern outside the table.
  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0111111;
      4'hB: return 7'b1111111;
      4'hC: return 7'b1110111;
      default: return 7'b1010101;
    endcase
  endfunction

  task automatic drive(input logic [3:0] an_v, input logic dp_v, input logic [6:0] seg_v,
                       input int n);
    @(negedge clk);
    an = an_v;
    dp = dp_v;
    a_to_g = seg_v;
    drive_cyc = cyc;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic show(input int idx, input logic [3:0] nib, input logic dp_on);
    logic [3:0] a;
    a = 4'b1111;
    a[idx] = 1'b0;
    drive(a, ~dp_on, enc(nib), 32);
  endtask

  task automatic scan_frame(input logic [15:0] v, input logic [3:0] dp_low, input exp_t e);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(e);
      show(i, v[4*i +: 4], dp_low[i]);
    end
  endtask

  // Monitor: every frame_done must match the oldest expected frame, 7 cycles after the
  // final digit was driven (2 sync + 4 settle + 1).
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (frame_done) begin
      check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("frame_x", 32'(x), 32'(e.x));
        check("frame_valid", 32'(valid), 32'd1);
        check("frame_dec_err", 32'(dec_err), 32'(e.dec));
        check("frame_dp_err", 32'(dp_err), 32'(e.dpe));
        check("frame_an_err", 32'(an_err), 32'(e.ane));
        check("frame_latency", 32'(cyc - drive_cyc), 32'd7);
      end
    end
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(x), 32'h0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_errs", 32'({dec_err, dp_err, an_err}), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // 1: clean scans of 1234
    scan_frame(16'h1234, 4'b0100, '{x: 16'h1234, dec: 1'b0, dpe: 1'b0, ane: 1'b0});
    check("t1_valid", 32'(valid), 32'd1);
    scan_frame(16'h1234, 4'b0100, '{x: 16'h1234, dec: 1'b0, dpe: 1'b0, ane: 1'b0});

    // 2: 3-cycle glitch on digit 1 must not be captured
    show(0, 4'h4, 1'b0);
    drive(4'b1101, 1'b1, enc(4'h9), 3);
    drive(4'b1101, 1'b1, enc(4'h3), 29);
    show(2, 4'h2, 1'b1);
    exp_q.push_back('{x: 16'h1234, dec: 1'b0, dpe: 1'b0, ane: 1'b0});
    show(3, 4'h1, 1'b0);

    // 3: undecodable pattern on digit 0
    scan_frame(16'h123F, 4'b0100, '{x: 16'h123F, dec: 1'b1, dpe: 1'b0, ane: 1'b0});

    // 4: extra dot on digit 0
    scan_frame(16'h1234, 4'b0101, '{x: 16'h1234, dec: 1'b1, dpe: 1'b1, ane: 1'b0});

    // 5: multi-anode and blanking dwells mid-frame
    show(0, 4'h8, 1'b0);
    show(1, 4'h7, 1'b0);
    show(2, 4'h6, 1'b1);
    drive(4'b0011, 1'b1, enc(4'h0), 32);
    check("t5_an_err", 32'(an_err), 32'd1);
    drive(4'b1111, 1'b1, 7'b1111111, 32);
    check("t5_valid_held", 32'(valid), 32'd1);
    exp_q.push_back('{x: 16'h5678, dec: 1'b1, dpe: 1'b1, ane: 1'b1});
    show(3, 4'h5, 1'b0);

    // 6: stop scanning; valid drops 256 cycles after the last frame
    drive(4'b1111, 1'b1, 7'b1111111, 200);
    check("t6_valid_before_tmo", 32'(valid), 32'd1);
    drive(4'b1111, 1'b1, 7'b1111111, 60);
    check("t6_valid_after_tmo", 32'(valid), 32'd0);
    check("t6_x_held", 32'(x), 32'h5678);

    // clr mid-frame
    show(0, 4'h4, 1'b0);
    show(1, 4'h3, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    an = 4'b1111;
    dp = 1'b1;
    a_to_g = 7'b1111111;
    @(posedge clk);
    #1;
    check("clr_x", 32'(x), 32'h0);
    check("clr_valid", 32'(valid), 32'd0);
    check("clr_errs", 32'({dec_err, dp_err, an_err}), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    show(2, 4'h2, 1'b1);
    show(3, 4'h1, 1'b0);
    check("clr_no_early_valid", 32'(valid), 32'd0);
    show(0, 4'h4, 1'b0);
    exp_q.push_back('{x: 16'h1234, dec: 1'b0, dpe: 1'b0, ane: 1'b0});
    show(1, 4'h3, 1'b0);
    check("clr_valid_restored", 32'(valid), 32'd1);

    drive(4'b1111, 1'b1, 7'b1111111, 16);
    check("all_frames_seen", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
